// File: rtl/hough_peak_select_pkg.sv
// Shared widths, queue control codes and FSM state encoding for hough_peak_select.
package hough_peak_select_pkg;

  localparam int unsigned msb_r          = 11;
  localparam int unsigned msb_phi        = 7;
  localparam int unsigned msb_votes      = 7;
  localparam int unsigned msb_ctrl_queue = 3;

  localparam int unsigned PHI_SPLIT_DEFAULT = 90;

  // {en, rw, sel_M[1:0]}
  localparam logic [msb_ctrl_queue:0] CQ_IDLE    = 4'b0000;
  localparam logic [msb_ctrl_queue:0] CQ_PUSH_M1 = 4'b1110;
  localparam logic [msb_ctrl_queue:0] CQ_PUSH_M2 = 4'b1101;

  typedef logic [1:0] state_t;
  localparam state_t ST_SCAN    = 2'd0;
  localparam state_t ST_PUSH_M1 = 2'd1;
  localparam state_t ST_PUSH_M2 = 2'd2;

endpackage

// File: rtl/hough_peak_select_peak_reg.sv
// One half-plane peak tracker: keeps the first strongest qualified cell of the frame.
module peak_reg
  import hough_peak_select_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               cand_i,
  input  logic [msb_r:0]     r_i,
  input  logic [msb_phi:0]   phi_i,
  input  logic [msb_votes:0] votes_i,
  output logic [msb_r:0]     r_o,
  output logic [msb_phi:0]   phi_o,
  output logic               valid_o
);

  logic [msb_r:0]     r_q;
  logic [msb_phi:0]   phi_q;
  logic [msb_votes:0] votes_q;
  logic               valid_q;
  logic               replace;

  // Strictly greater so a tie keeps the earlier cell.
  assign replace = cand_i & (~valid_q | (votes_i > votes_q));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_q     <= '0;
      phi_q   <= '0;
      votes_q <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      // Position is kept; only the compare state restarts for the next frame.
      votes_q <= '0;
      valid_q <= 1'b0;
    end else if (replace) begin
      r_q     <= r_i;
      phi_q   <= phi_i;
      votes_q <= votes_i;
      valid_q <= 1'b1;
    end
  end

  assign r_o     = r_q;
  assign phi_o   = phi_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/hough_peak_select.sv
// Picks strongest left/right Hough peaks per frame and pushes them to the lane queue.
// Optional HOUGH_PEAK_HOLD_EN: a side with no peak reuses the previous frame's pushed peak.
module hough_peak_select
  import hough_peak_select_pkg::*;
#(
  parameter int unsigned PHI_SPLIT = PHI_SPLIT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic [msb_r:0]          acc_r,
  input  logic [msb_phi:0]        acc_phi,
  input  logic [msb_votes:0]      acc_votes,
  input  logic                    acc_last,
  input  logic [msb_votes:0]      threshold,
  output logic [msb_r:0]          M1_r,
  output logic [msb_phi:0]        M1_phi,
  output logic [msb_r:0]          M2_r,
  output logic [msb_phi:0]        M2_phi,
  output logic [msb_ctrl_queue:0] ctrl_queue,
  output logic                    frame_done
);

  localparam logic [msb_phi:0] PhiSplit = PHI_SPLIT[msb_phi:0];

  state_t state_q, state_d;

  logic           beat;
  logic           qual;
  logic           is_left;
  logic           clear;
  logic [msb_r:0] m1_r, m2_r;
  logic [msb_phi:0] m1_phi, m2_phi;
  logic           m1_valid, m2_valid;
  logic           push_m1_en, push_m2_en;

  assign acc_ready = (state_q == ST_SCAN);
  assign beat      = acc_valid & acc_ready;
  assign qual      = beat & (acc_votes >= threshold);
  assign is_left   = (acc_phi < PhiSplit);
  assign clear     = (state_q == ST_PUSH_M2);

  peak_reg u_peak_m1 (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (clear),
    .cand_i  (qual & is_left),
    .r_i     (acc_r),
    .phi_i   (acc_phi),
    .votes_i (acc_votes),
    .r_o     (m1_r),
    .phi_o   (m1_phi),
    .valid_o (m1_valid)
  );

  peak_reg u_peak_m2 (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (clear),
    .cand_i  (qual & ~is_left),
    .r_i     (acc_r),
    .phi_i   (acc_phi),
    .votes_i (acc_votes),
    .r_o     (m2_r),
    .phi_o   (m2_phi),
    .valid_o (m2_valid)
  );

`ifdef HOUGH_PEAK_HOLD_EN
  logic [msb_r:0]   hold1_r_q, hold2_r_q;
  logic [msb_phi:0] hold1_phi_q, hold2_phi_q;
  logic             hold1_valid_q, hold2_valid_q;

  // Capture what this frame actually pushed from its own cells; hold flags clear only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold1_r_q     <= '0;
      hold1_phi_q   <= '0;
      hold1_valid_q <= 1'b0;
      hold2_r_q     <= '0;
      hold2_phi_q   <= '0;
      hold2_valid_q <= 1'b0;
    end else if (state_q == ST_PUSH_M2) begin
      if (m1_valid) begin
        hold1_r_q     <= m1_r;
        hold1_phi_q   <= m1_phi;
        hold1_valid_q <= 1'b1;
      end
      if (m2_valid) begin
        hold2_r_q     <= m2_r;
        hold2_phi_q   <= m2_phi;
        hold2_valid_q <= 1'b1;
      end
    end
  end

  assign push_m1_en = m1_valid | hold1_valid_q;
  assign push_m2_en = m2_valid | hold2_valid_q;
  assign M1_r   = (!m1_valid && hold1_valid_q) ? hold1_r_q   : m1_r;
  assign M1_phi = (!m1_valid && hold1_valid_q) ? hold1_phi_q : m1_phi;
  assign M2_r   = (!m2_valid && hold2_valid_q) ? hold2_r_q   : m2_r;
  assign M2_phi = (!m2_valid && hold2_valid_q) ? hold2_phi_q : m2_phi;
`else
  assign push_m1_en = m1_valid;
  assign push_m2_en = m2_valid;
  assign M1_r   = m1_r;
  assign M1_phi = m1_phi;
  assign M2_r   = m2_r;
  assign M2_phi = m2_phi;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SCAN:    if (beat && acc_last) state_d = ST_PUSH_M1;
      ST_PUSH_M1: state_d = ST_PUSH_M2;
      ST_PUSH_M2: state_d = ST_SCAN;
      default:    state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  // Masked by reset so an aborted push never presents a write on the reset cycle.
  always_comb begin
    ctrl_queue = CQ_IDLE;
    frame_done = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_PUSH_M1: ctrl_queue = push_m1_en ? CQ_PUSH_M1 : CQ_IDLE;
        ST_PUSH_M2: begin
          ctrl_queue = push_m2_en ? CQ_PUSH_M2 : CQ_IDLE;
          frame_done = 1'b1;
        end
        default: ctrl_queue = CQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hough_peak_select.sv
// Directed self-checking bench for hough_peak_select (both HOUGH_PEAK_HOLD_EN builds).
module tb_hough_peak_select;

  logic        clk;
  logic        reset;
  logic        acc_valid;
  logic        acc_ready;
  logic [11:0] acc_r;
  logic [7:0]  acc_phi;
  logic [7:0]  acc_votes;
  logic        acc_last;
  logic [7:0]  threshold;
  logic [11:0] M1_r, M2_r;
  logic [7:0]  M1_phi, M2_phi;
  logic [3:0]  ctrl_queue;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  hough_peak_select dut (
    .clk        (clk),
    .reset      (reset),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_r      (acc_r),
    .acc_phi    (acc_phi),
    .acc_votes  (acc_votes),
    .acc_last   (acc_last),
    .threshold  (threshold),
    .M1_r       (M1_r),
    .M1_phi     (M1_phi),
    .M2_r       (M2_r),
    .M2_phi     (M2_phi),
    .ctrl_queue (ctrl_queue),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cell and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [11:0] r, input logic [7:0] phi, input logic [7:0] v,
                      input logic last);
    int  waited;
    bit  got;
    waited = 0;
    got    = 0;
    acc_valid = 1'b1;
    acc_r     = r;
    acc_phi   = phi;
    acc_votes = v;
    acc_last  = last;
    while (!got && waited < 8) begin
      @(negedge clk);
      if (acc_ready) got = 1;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
    acc_valid = 1'b0;
    acc_last  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    acc_valid = 1'b0;
    acc_r     = '0;
    acc_phi   = '0;
    acc_votes = '0;
    acc_last  = 1'b0;
    threshold = 8'd10;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_ctrl", ctrl_queue, 4'b0000);
    check("rst_ready", acc_ready, 1'b1);
    check("rst_m1_r", M1_r, 12'd0);
    check("rst_done", frame_done, 1'b0);
    @(posedge clk);
    #1;

    // Split and push
    send(12'd100, 8'd30, 8'd20, 1'b0);
    send(12'd200, 8'd120, 8'd15, 1'b0);
    send(12'd50, 8'd40, 8'd25, 1'b1);
    @(negedge clk);
    check("f1_ctrl_m1", ctrl_queue, 4'b1110);
    check("f1_ready_n1", acc_ready, 1'b0);
    check("f1_done_n1", frame_done, 1'b0);
    check("f1_m1_r", M1_r, 12'd50);
    check("f1_m1_phi", M1_phi, 8'd40);
    check("f1_m2_r", M2_r, 12'd200);
    check("f1_m2_phi", M2_phi, 8'd120);
    @(negedge clk);
    check("f1_ctrl_m2", ctrl_queue, 4'b1101);
    check("f1_done_n2", frame_done, 1'b1);
    check("f1_ready_n2", acc_ready, 1'b0);
    @(negedge clk);
    check("f1_ctrl_idle", ctrl_queue, 4'b0000);
    check("f1_ready_n3", acc_ready, 1'b1);
    check("f1_done_n3", frame_done, 1'b0);
    @(posedge clk);
    #1;

    // Tie and below threshold
    send(12'd5, 8'd10, 8'd30, 1'b0);
    send(12'd6, 8'd11, 8'd30, 1'b0);
    send(12'd7, 8'd12, 8'd9, 1'b1);
    @(negedge clk);
    check("f2_ctrl_m1", ctrl_queue, 4'b1110);
    check("f2_m1_r", M1_r, 12'd5);
    check("f2_m1_phi", M1_phi, 8'd10);
    @(negedge clk);
`ifdef HOUGH_PEAK_HOLD_EN
    check("f2_ctrl_m2", ctrl_queue, 4'b1101);
`else
    check("f2_ctrl_m2", ctrl_queue, 4'b0000);
`endif
    check("f2_done", frame_done, 1'b1);
    @(posedge clk);
    #1;

    // Single-beat right-only frame, then backpressure with acc_valid held through push
    send(12'd300, 8'd100, 8'd40, 1'b1);
    acc_valid = 1'b1;
    acc_r     = 12'd400;
    acc_phi   = 8'd20;
    acc_votes = 8'd50;
    acc_last  = 1'b0;
    @(negedge clk);
    check("bp_ready_n1", acc_ready, 1'b0);
`ifdef HOUGH_PEAK_HOLD_EN
    check("f3_ctrl_m1", ctrl_queue, 4'b1110);
`else
    check("f3_ctrl_m1", ctrl_queue, 4'b0000);
`endif
    check("f3_m2_r", M2_r, 12'd300);
    check("f3_m2_phi", M2_phi, 8'd100);
    @(negedge clk);
    check("bp_ready_n2", acc_ready, 1'b0);
    check("f3_ctrl_m2", ctrl_queue, 4'b1101);
    @(negedge clk);
    check("bp_ready_n3", acc_ready, 1'b1);
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    send(12'd10, 8'd50, 8'd12, 1'b1);
    @(negedge clk);
    check("f4_ctrl_m1", ctrl_queue, 4'b1110);
    check("f4_m1_r", M1_r, 12'd400);
    check("f4_m1_phi", M1_phi, 8'd20);
    @(negedge clk);
`ifdef HOUGH_PEAK_HOLD_EN
    check("f4_ctrl_m2", ctrl_queue, 4'b1101);
`else
    check("f4_ctrl_m2", ctrl_queue, 4'b0000);
`endif
    check("f4_m2_r", M2_r, 12'd300);
    check("f4_m2_phi", M2_phi, 8'd100);
    @(negedge clk);
    check("f4_ready_after", acc_ready, 1'b1);
    @(posedge clk);
    #1;

    // Reset during PUSH_M1 aborts the sequence
    send(12'd1, 8'd100, 8'd50, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rp_ctrl_rst", ctrl_queue, 4'b0000);
    check("rp_done_rst", frame_done, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rp_ctrl_after", ctrl_queue, 4'b0000);
      check("rp_ready_after", acc_ready, 1'b1);
    end
    check("rp_m2_r", M2_r, 12'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
